// File: rtl/mem_access_stage_if.sv
// Single-beat 8-bit data-memory bus between the MEM stage (master) and memory (slave).
interface mem_access_stage_if #(
  parameter int ADDR_W = 16
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: byte/word loads and stores over an 8-bit req/ack bus, stalls upstream meanwhile.
// Define MEM_TIMEOUT_EN to build the per-byte ack timeout that reports through Bus_err.
module mem_access_stage #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2:0]         Mem_op,
  input  logic [4:0]         Wr_id_in,
  input  logic [7:0]         Fmask_in,
  input  logic [15:0]        Result_in,
  input  logic [7:0]         Flags_in,
  input  logic [15:0]        Store_data,
  input  logic               Stall_in,
  output logic [4:0]         Wr_id_out,
  output logic [7:0]         Fmask_out,
  output logic [15:0]        Result_out,
  output logic [7:0]         Flags_out,
  output logic               stall,
  mem_access_stage_if.master bus,
  output logic               Bus_err
);

  localparam logic [2:0] OP_READ8   = 3'd1;
  localparam logic [2:0] OP_WRITE8  = 3'd2;
  localparam logic [2:0] OP_READ16  = 3'd3;
  localparam logic [2:0] OP_WRITE16 = 3'd4;

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rd_lo_q, rd_lo_d;
  logic [7:0]        rd_hi_q, rd_hi_d;
  logic [2:0]        op_q, op_d;

  logic              op_valid;
  logic              op_is_write;
  logic              op_wide;
  logic              ack_eff;
  logic [7:0]        rdata_eff;

  // Codes 5-7 are not memory operations and pass through like NONE.
  assign op_valid    = (Mem_op >= OP_READ8) && (Mem_op <= OP_WRITE16);
  assign op_is_write = (Mem_op == OP_WRITE8) || (Mem_op == OP_WRITE16);
  assign op_wide     = (op_q == OP_READ16) || (op_q == OP_WRITE16);

  assign Wr_id_out = Wr_id_in;
  assign Fmask_out = Fmask_in;
  assign Flags_out = Flags_in;

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
  logic       timed_out;

  // A byte that waited the full limit completes as if acked with all-ones data.
  assign timed_out = ((state_q == BYTE0) || (state_q == BYTE1)) && !bus.mem_ack &&
                     (wait_q == 8'(TIMEOUT_CYCLES));
  assign ack_eff   = bus.mem_ack | timed_out;
  assign rdata_eff = timed_out ? 8'hFF : bus.mem_rdata;
  assign Bus_err   = err_q && (state_q == DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
`else
  assign ack_eff   = bus.mem_ack;
  assign rdata_eff = bus.mem_rdata;
  assign Bus_err   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_lo_q <= '0;
      rd_hi_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_lo_q <= rd_lo_d;
      rd_hi_q <= rd_hi_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_lo_d    = rd_lo_q;
    rd_hi_d    = rd_hi_q;
    op_d       = op_q;
    stall      = 1'b0;
    Result_out = Result_in;
`ifdef MEM_TIMEOUT_EN
    wait_d     = wait_q;
    err_d      = err_q;
`endif

    case (state_q)
      IDLE: begin
        // Launch is not gated by Stall_in; the stage owns the pipeline until DONE.
        if (op_valid) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = op_is_write;
          addr_d  = Result_in[ADDR_W-1:0];
          wdata_d = Store_data[7:0];
          op_d    = Mem_op;
          state_d = BYTE0;
`ifdef MEM_TIMEOUT_EN
          wait_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end

      BYTE0: begin
        stall = 1'b1;
        if (ack_eff) begin
          rd_lo_d = rdata_eff;
          if (op_wide) begin
            addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            wdata_d = Store_data[15:8];
            state_d = BYTE1;
          end else begin
            req_d   = 1'b0;
            state_d = DONE;
          end
`ifdef MEM_TIMEOUT_EN
          wait_d = '0;
          if (timed_out) err_d = 1'b1;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
          wait_d = wait_q + 8'd1;
`endif
        end
      end

      BYTE1: begin
        stall = 1'b1;
        if (ack_eff) begin
          rd_hi_d = rdata_eff;
          req_d   = 1'b0;
          state_d = DONE;
`ifdef MEM_TIMEOUT_EN
          if (timed_out) err_d = 1'b1;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
          wait_d = wait_q + 8'd1;
`endif
        end
      end

      DONE: begin
        case (op_q)
          OP_READ8:  Result_out = {8'h00, rd_lo_q};
          OP_READ16: Result_out = {rd_hi_q, rd_lo_q};
          default:   Result_out = Result_in;
        endcase
        if (!Stall_in) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver queues expected results, monitor and bus slave check them.
module tb_mem_access_stage;

  localparam logic [2:0] OP_NONE    = 3'd0;
  localparam logic [2:0] OP_READ8   = 3'd1;
  localparam logic [2:0] OP_WRITE8  = 3'd2;
  localparam logic [2:0] OP_READ16  = 3'd3;
  localparam logic [2:0] OP_WRITE16 = 3'd4;

  typedef struct {
    logic [15:0] res;
    int          stalls;
    logic        err;
    logic [4:0]  wrid;
    logic [7:0]  fmask;
    logic [7:0]  flags;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_t;

  logic        CLK;
  logic        RST;
  logic [2:0]  Mem_op;
  logic [4:0]  Wr_id_in;
  logic [7:0]  Fmask_in;
  logic [15:0] Result_in;
  logic [7:0]  Flags_in;
  logic [15:0] Store_data;
  logic        Stall_in;
  logic [4:0]  Wr_id_out;
  logic [7:0]  Fmask_out;
  logic [15:0] Result_out;
  logic [7:0]  Flags_out;
  logic        stall;
  logic        Bus_err;

  mem_access_stage_if #(.ADDR_W(16)) bus ();

  mem_access_stage #(.ADDR_W(16), .TIMEOUT_CYCLES(255)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Mem_op     (Mem_op),
    .Wr_id_in   (Wr_id_in),
    .Fmask_in   (Fmask_in),
    .Result_in  (Result_in),
    .Flags_in   (Flags_in),
    .Store_data (Store_data),
    .Stall_in   (Stall_in),
    .Wr_id_out  (Wr_id_out),
    .Fmask_out  (Fmask_out),
    .Result_out (Result_out),
    .Flags_out  (Flags_out),
    .stall      (stall),
    .bus        (bus),
    .Bus_err    (Bus_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  bus_t exp_bus[$];
  logic [7:0] rd_q[$];
  logic valid;
  logic slave_mute;
  int   ack_delay;
  int   op_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory slave: acks each byte after ack_delay wait cycles and checks the bus beat.
  int wcnt = 0;
  always @(negedge CLK) begin
    bus.mem_ack = 1'b0;
    if (RST || !bus.mem_req || slave_mute) begin
      wcnt = 0;
    end else if (wcnt >= ack_delay) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
      wcnt = 0;
      if (exp_bus.size() == 0) begin
        check("bus_unexpected_beat", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end else begin
        bus_t b;
        b = exp_bus.pop_front();
        check("bus_we", 32'(bus.mem_we), 32'(b.we));
        check("bus_addr", 32'(bus.mem_addr), 32'(b.addr));
        if (b.we) check("bus_wdata", 32'(bus.mem_wdata), 32'(b.wdata));
        $display("bus beat we=%0d addr=%h wdata=%h rdata=%h", bus.mem_we, bus.mem_addr,
                 bus.mem_wdata, bus.mem_rdata);
      end
    end else begin
      wcnt++;
    end
  end

  // Monitor: counts stall cycles of the presented op, compares when the stage releases it.
  int scnt = 0;
  always @(negedge CLK) begin
    if (RST || !valid) begin
      scnt = 0;
    end else if (stall) begin
      scnt++;
    end else begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(Result_out), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 32'(Result_out), 32'(e.res));
        check("stall_cycles", 32'(scnt), 32'(e.stalls));
        check("bus_err", 32'(Bus_err), 32'(e.err));
        check("wr_id", 32'(Wr_id_out), 32'(e.wrid));
        check("fmask", 32'(Fmask_out), 32'(e.fmask));
        check("flags", 32'(Flags_out), 32'(e.flags));
        check("req_low_at_output", 32'(bus.mem_req), 32'd0);
        $display("txn result=%h stall_cycles=%0d bus_err=%0d", Result_out, scnt, Bus_err);
      end
      scnt = 0;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [15:0] res, input logic [15:0] sd,
                       input int ack_d, input int hold, input logic [15:0] exp_res,
                       input int exp_stalls, input logic exp_err);
    int   budget;
    exp_t e;
    op_idx++;
    ack_delay  = ack_d;
    Mem_op     = op;
    Result_in  = res;
    Store_data = sd;
    Wr_id_in   = 5'(op_idx);
    Fmask_in   = 8'(op_idx * 17);
    Flags_in   = ~8'(op_idx);
    Stall_in   = 1'b0;
    valid      = 1'b1;
    for (int k = 0; k <= hold; k++) begin
      e.res    = exp_res;
      e.stalls = (k == 0) ? exp_stalls : 0;
      e.err    = exp_err;
      e.wrid   = Wr_id_in;
      e.fmask  = Fmask_in;
      e.flags  = Flags_in;
      exp_q.push_back(e);
    end
    #1;
    budget = 0;
    while (stall !== 1'b0 && budget < 2000) begin
      @(posedge CLK); #1;
      budget++;
    end
    if (budget >= 2000) check("op_completion_timeout", 32'(budget), 32'd0);
    for (int k = 0; k < hold; k++) begin
      Stall_in = 1'b1;
      @(posedge CLK); #1;
    end
    Stall_in = 1'b0;
    @(posedge CLK); #1;
    valid  = 1'b0;
    Mem_op = OP_NONE;
  endtask

  function automatic bus_t mk(input logic we, input logic [15:0] a, input logic [7:0] d);
    bus_t b;
    b.we = we; b.addr = a; b.wdata = d;
    return b;
  endfunction

  initial begin
    int budget;
    RST = 1'b1; Mem_op = OP_NONE; Wr_id_in = '0; Fmask_in = '0; Result_in = '0;
    Flags_in = '0; Store_data = '0; Stall_in = 1'b0; valid = 1'b0;
    slave_mute = 1'b0; ack_delay = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_bus_err", 32'(Bus_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Pass-through and pseudo-NONE codes
    issue(OP_NONE, 16'h1234, 16'h0000, 0, 0, 16'h1234, 0, 1'b0);
    issue(3'd6, 16'h4321, 16'h9999, 0, 0, 16'h4321, 0, 1'b0);

    // READ8, ack two cycles after req
    exp_bus.push_back(mk(1'b0, 16'hC000, 8'h00)); rd_q.push_back(8'h5A);
    issue(OP_READ8, 16'hC000, 16'h0000, 2, 0, 16'h005A, 4, 1'b0);

    // WRITE16 across the address wrap, zero-wait
    exp_bus.push_back(mk(1'b1, 16'hFFFF, 8'hEF));
    exp_bus.push_back(mk(1'b1, 16'h0000, 8'hBE));
    issue(OP_WRITE16, 16'hFFFF, 16'hBEEF, 0, 0, 16'hFFFF, 3, 1'b0);

    // READ16 held in DONE for two cycles by Stall_in
    exp_bus.push_back(mk(1'b0, 16'h0100, 8'h00)); rd_q.push_back(8'h34);
    exp_bus.push_back(mk(1'b0, 16'h0101, 8'h00)); rd_q.push_back(8'h12);
    issue(OP_READ16, 16'h0100, 16'h0000, 0, 2, 16'h1234, 3, 1'b0);

    // WRITE8 with one wait cycle
    exp_bus.push_back(mk(1'b1, 16'h00A5, 8'h77));
    issue(OP_WRITE8, 16'h00A5, 16'h1177, 1, 0, 16'h00A5, 3, 1'b0);

    // READ16 with one wait cycle per byte
    exp_bus.push_back(mk(1'b0, 16'h7FFF, 8'h00)); rd_q.push_back(8'hCD);
    exp_bus.push_back(mk(1'b0, 16'h8000, 8'h00)); rd_q.push_back(8'hAB);
    issue(OP_READ16, 16'h7FFF, 16'h0000, 1, 0, 16'hABCD, 5, 1'b0);

    // Reset during the second byte of a READ16
    ack_delay = 3;
    exp_bus.push_back(mk(1'b0, 16'h0200, 8'h00)); rd_q.push_back(8'hAA);
    Mem_op = OP_READ16; Result_in = 16'h0200; valid = 1'b1;
    budget = 0;
    do begin
      @(posedge CLK); #1;
      budget++;
    end while (bus.mem_addr !== 16'h0201 && budget < 100);
    check("reach_byte1", 32'(bus.mem_addr), 32'h0201);
    RST = 1'b1; valid = 1'b0; Mem_op = OP_NONE;
    @(posedge CLK); #1;
    check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    check("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst_stall_none", 32'(stall), 32'd0);
    Mem_op = OP_READ8; #1;
    check("midrst_stall_op", 32'(stall), 32'd1);
    Mem_op = OP_NONE;
    @(posedge CLK); #1;
    RST = 1'b0;
    ack_delay = 0;
    @(posedge CLK); #1;

    issue(OP_NONE, 16'h5555, 16'h0000, 0, 0, 16'h5555, 0, 1'b0);

    // Memory that never acks
    slave_mute = 1'b1;
`ifdef MEM_TIMEOUT_EN
    issue(OP_READ8, 16'h3000, 16'h0000, 0, 1, 16'h00FF, 257, 1'b1);
    issue(OP_NONE, 16'h0042, 16'h0000, 0, 0, 16'h0042, 0, 1'b0);
`else
    Mem_op = OP_READ8; Result_in = 16'h3000;
    repeat (1000) @(posedge CLK);
    #1;
    check("noack_stall_held", 32'(stall), 32'd1);
    check("noack_req_held", 32'(bus.mem_req), 32'd1);
    RST = 1'b1; Mem_op = OP_NONE;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("noack_rst_req", 32'(bus.mem_req), 32'd0);
    check("noack_bus_err", 32'(Bus_err), 32'd0);
`endif
    slave_mute = 1'b0;

    repeat (4) @(posedge CLK);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_bus_drained", 32'(exp_bus.size()), 32'd0);
    check("rdata_drained", 32'(rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
